mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data-memory bus, directly downstream of the `top` core's load/store path. It consumes store traffic decoded to its address window and buffers bytes in a small FIFO. A baud-rate FSM serialises them as 8N1 frames on `tx`. It also exposes a combinationally readable status word, so single-cycle loads complete in the same cycle.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries; power of two, ≥ 2.
- `BASE_ADDR`, default 32'h1000_0000: word-aligned base of the register window.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; state is cleared while `reset`=0.
- `mem_write`  in  1  CPU store strobe, valid for one cycle.
- `mem_read`  in  1  CPU load strobe.
- `addr`  in  32  byte address from the CPU ALU.
- `write_data`  in  32  store data; only bits [7:0] (TXDATA) or bit 3 (STATUS) are used.
- `read_data`  out  32  combinational load data; 0 when not hit.
- `hit`  out  1  combinational; `addr` is BASE_ADDR+0 or BASE_ADDR+4.
- `tx`  out  1  registered serial line; idle high.
- `tx_busy`  out  1  frame in progress or FIFO non-empty.

## Operation
- Register map:
  - **BASE+0, TXDATA:** write-only; reads return 0.
  - **BASE+4, STATUS:** bit0 = fifo_full, bit1 = fifo_empty, bit2 = tx_busy, bit3 = overflow (sticky).
  - Writing STATUS with bit3=1 clears overflow; all other written bits are ignored.
  - Any other address is ignored and gives `hit`=0.
- **Push:** `mem_write` to TXDATA pushes `write_data[7:0]`.
  - If the FIFO is full after accounting for a same-cycle pop, the byte is dropped and overflow is set.
  - Push and pop in the same cycle while full: the pop frees a slot and the push is accepted.
  - A same-cycle overflow set and W1C clear resolve as set.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** if the FIFO is non-empty, pop the head into the shift register, go to START, drive `tx`=0.
  - **START:** hold for CLKS_PER_BIT cycles, then go to DATA with `tx`=bit0.
  - **DATA:** 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit index counts 0..7, then go to STOP with `tx`=1.
  - **STOP:** hold CLKS_PER_BIT cycles. If the FIFO is non-empty, pop directly into START (no idle gap); otherwise go to IDLE.
- **Baud counter:** width $clog2(CLKS_PER_BIT). It loads CLKS_PER_BIT-1 on every state/bit change, decrements each cycle, and advances at 0.
- **FIFO:** pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count is $clog2(FIFO_DEPTH)+1 bits.
- **Reset values:** `tx`=1, FSM=IDLE, FIFO empty, overflow=0. Resulting status = 32'h2, `tx_busy`=0.
- **Reset mid-frame:** `tx` returns high immediately and queued bytes are discarded. No partial frame resumes after release.

## Timing
- Store accepted at edge k, with the FIFO empty and the FSM in IDLE:
  - The pop and `tx`=0 are registered at edge k+1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - The frame is 10·CLKS_PER_BIT cycles; `tx` is back high at edge k+1+9·CLKS_PER_BIT.
- Consecutive queued bytes: frame period is exactly 10·CLKS_PER_BIT cycles with no idle cycle.
- `read_data` and `hit` have zero latency (combinational from `addr` and state).
- Status reflects registered state, i.e. updates from the previous edge.
- `tx_busy` is combinational: FSM≠IDLE or FIFO non-empty.

## Structure
- **Package `mmio_pkg`:**
  - UART_BASE;
  - offsets TXDATA_OFS=0, STATUS_OFS=4;
  - status bit indices;
  - `uart_state_t` enum (IDLE/START/DATA/STOP).
- **Sub-module `sync_fifo`:** parameterised width and depth, with push/pop/full/empty/count. Reusable for a later RX path.
- **Top-level integration:** `top` ORs `read_data` into the load mux when `hit`=1, and gates the data-memory write-enable with !`hit`.

## Test plan
All tests use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
1. **Reset:** hold `reset`=0 for 2 cycles, then read BASE+4 → `read_data`=32'h2, `tx`=1, `tx_busy`=0.
2. **Single byte:** store 0x55 to BASE+0 at edge k → `tx` low from k+1. Then `tx` reads 1,0,1,0,1,0,1,0 (LSB first), each held 4 cycles, then stop=1; `tx_busy` falls at k+41.
3. **Overflow:** 10 stores on consecutive cycles (0x00..0x09) → bytes 0x00..0x08 are transmitted, 0x09 is dropped, and STATUS = full|busy|overflow (32'hD). Writing STATUS=0x8 clears bit3.
4. **Back-to-back frames:** queue 0xA5 and 0x3C → two frames 80 cycles total, with no idle-high cycle between the stop bit and the next start bit.
5. **Reset mid-frame:** assert `reset`=0 during DATA bit 3 with 3 bytes queued → `tx`=1 asynchronously; after release, no transmission occurs and STATUS=32'h2.
6. **Address decode:** a store to BASE+8 or 0x0000_0100 → `hit`=0, FIFO unchanged, `tx` stays 1; a load from BASE+0 → `read_data`=0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// status bit positions and the transmit FSM state type.
package mmio_pkg;

  localparam logic [31:0] UART_BASE  = 32'h1000_0000;
  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int STAT_FULL     = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_OVERFLOW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic busy, input logic overflow);
    logic [31:0] s;
    s                = '0;
    s[STAT_FULL]     = full;
    s[STAT_EMPTY]    = empty;
    s[STAT_BUSY]     = busy;
    s[STAT_OVERFLOW] = overflow;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers and an occupancy counter.
// Reusable for both transmit and receive byte paths.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Handshake: push/pop are requests; a pop is taken only when non-empty, and
  // a push is taken when a slot is free or a same-cycle pop frees one.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: store-fed TX FIFO, baud-rate FSM and a
// combinationally readable status word for single-cycle loads.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = UART_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        tx,
  output logic        tx_busy,
  output uart_state_t dbg_state
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_q, tx_n;
  logic          fsm_pop;

  logic          hit_txdata;
  logic          hit_status;
  logic          wr_txdata;
  logic          wr_status;
  logic          overflow;
  logic          ovf_set;
  logic          ovf_clr;

  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;

  // Register decode
  assign hit_txdata = (addr == BASE_ADDR + TXDATA_OFS);
  assign hit_status = (addr == BASE_ADDR + STATUS_OFS);
  assign hit        = hit_txdata || hit_status;
  assign wr_txdata  = mem_write && hit_txdata;
  assign wr_status  = mem_write && hit_status;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_txdata),
    .wdata (write_data[7:0]),
    .pop   (fsm_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A push into a full FIFO survives only if the FSM pops in the same cycle.
  assign ovf_set = wr_txdata && fifo_full && !fsm_pop;
  assign ovf_clr = wr_status && write_data[STAT_OVERFLOW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign tx_busy   = (state != IDLE) || (fifo_count != '0);
  assign status    = pack_status(fifo_full, fifo_empty, tx_busy, overflow);
  assign read_data = (mem_read && hit_status) ? status : 32'h0;
  assign tx        = tx_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx_q    <= tx_n;
    end
  end

  // The shift register moves right each data bit, so tx always takes shift[1]
  // when stepping to the next bit.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = tx_q;
    fsm_pop = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fsm_pop = 1'b1;
          shift_n = fifo_rdata;
          tx_n    = 1'b0;
          baud_n  = BAUD_MAX;
          state_n = START;
        end
      end
      START: begin
        if (baud == '0) begin
          state_n = DATA;
          tx_n    = shift[0];
          baud_n  = BAUD_MAX;
          bit_n   = 3'd0;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_n = BAUD_MAX;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      STOP: begin
        if (baud == '0) begin
          if (!fifo_empty) begin
            fsm_pop = 1'b1;
            shift_n = fifo_rdata;
            tx_n    = 1'b0;
            baud_n  = BAUD_MAX;
            state_n = START;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8; a serial
// monitor decodes frames on tx against a queue of expected bytes.
module tb_mmio_uart_tx;
  import mmio_pkg::*;

  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        hit;
  logic        tx;
  logic        tx_busy;
  uart_state_t dbg_state;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b1;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .hit        (hit),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Serial monitor: samples mid-bit, 2 time units after each rising edge.
  initial begin
    logic [7:0] rx;
    forever begin
      @(posedge clk); #2;
      if (reset && tx === 1'b0) begin
        repeat (5) @(posedge clk);
        #2 rx[0] = tx;
        for (int i = 1; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #2 rx[i] = tx;
        end
        repeat (CPB) @(posedge clk);
        #2;
        if (mon_en) begin
          checks++;
          if (tx !== 1'b1) begin
            failures++;
            $display("FAIL mon_stop_bit got=%b exp=1", tx);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL mon_unexpected_byte got=%h exp=none", rx);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rx !== e) begin
              failures++;
              $display("FAIL mon_byte got=%h exp=%h", rx, e);
            end
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    addr       = a;
    write_data = d;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    addr      = '0;
  endtask

  task automatic read_status(input logic [31:0] exp, input string name);
    mem_read = 1'b1;
    addr     = BASE + 32'h4;
    #1;
    checks++;
    if (read_data !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, read_data, exp);
    end
    mem_read = 1'b0;
    addr     = '0;
  endtask

  // Checks tx every cycle from cycle c0 to 40 of a frame whose store edge is k.
  task automatic expect_frame(input logic [7:0] b, input int c0, input string name);
    logic e;
    int   bad_c;
    logic bad_v;
    bad_c = -1;
    bad_v = 1'b0;
    for (int c = c0; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c <= 4)       e = 1'b0;
      else if (c <= 36) e = b[(c - 5) / 4];
      else              e = 1'b1;
      if (tx !== e && bad_c < 0) begin
        bad_c = c;
        bad_v = tx;
      end
    end
    checks++;
    if (bad_c >= 0) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b", name, bad_c, bad_v);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL %s timeout remaining=%0d busy=%b", name, exp_q.size(), tx_busy);
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    read_status(32'h2, "reset_status");
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++;
    if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    checks++;
    if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_single_byte();
    exp_q.push_back(8'h55);
    bus_write(BASE, 32'h55);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL single_pre_tx got=%b exp=1", tx); end
    expect_frame(8'h55, 1, "single_wave");
    checks++;
    if (tx_busy !== 1'b1) begin failures++; $display("FAIL single_busy_k40 got=%b exp=1", tx_busy); end
    @(posedge clk); #1;
    checks++;
    if (tx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_k41 got=%b exp=0", tx_busy); end
    wait_drain("single_drain");
  endtask

  task automatic test_overflow();
    @(negedge clk);
    mem_write = 1'b1;
    addr      = BASE;
    for (int i = 0; i < 10; i++) begin
      write_data = 32'(i);
      if (i < 9) exp_q.push_back(8'(i));
      @(posedge clk);
      #1;
    end
    mem_write = 1'b0;
    addr      = '0;
    read_status(32'hD, "ovf_status");
    bus_write(BASE + 32'h4, 32'h7);
    read_status(32'hD, "ovf_w_other_bits");
    bus_write(BASE + 32'h4, 32'h8);
    read_status(32'h5, "ovf_cleared");
    wait_drain("ovf_drain");
    read_status(32'h2, "ovf_idle_status");
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    @(negedge clk);
    mem_write  = 1'b1;
    addr       = BASE;
    write_data = 32'hA5;
    @(posedge clk);
    #1 write_data = 32'h3C;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    addr      = '0;
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL b2b_start got=%b exp=0", tx); end
    expect_frame(8'hA5, 2, "b2b_first");
    expect_frame(8'h3C, 1, "b2b_second");
    @(posedge clk); #1;
    checks++;
    if (tx_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", tx_busy); end
    wait_drain("b2b_drain");
  endtask

  task automatic test_reset_mid_frame();
    logic bad;
    mon_en = 1'b0;
    bus_write(BASE, 32'h81);
    bus_write(BASE, 32'h42);
    bus_write(BASE, 32'h24);
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (dbg_state !== DATA) begin failures++; $display("FAIL mid_state got=%0d exp=2", dbg_state); end
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL mid_async_tx got=%b exp=1", tx); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL mid_no_resume got=0 exp=1"); end
    read_status(32'h2, "mid_status");
    mon_en = 1'b1;
  endtask

  task automatic test_addr_decode();
    logic bad;
    @(negedge clk);
    mem_write  = 1'b1;
    addr       = BASE + 32'h8;
    write_data = 32'h41;
    #1;
    checks++;
    if (hit !== 1'b0) begin failures++; $display("FAIL dec_hit_base8 got=%b exp=0", hit); end
    @(posedge clk);
    #1 addr = 32'h0000_0100;
    #1;
    checks++;
    if (hit !== 1'b0) begin failures++; $display("FAIL dec_hit_0100 got=%b exp=0", hit); end
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    addr      = '0;
    read_status(32'h2, "dec_status");
    mem_read = 1'b1;
    addr     = BASE;
    #1;
    checks++;
    if (read_data !== 32'h0) begin failures++; $display("FAIL dec_read_txdata got=%h exp=0", read_data); end
    checks++;
    if (hit !== 1'b1) begin failures++; $display("FAIL dec_hit_txdata got=%b exp=1", hit); end
    addr = BASE + 32'h8;
    #1;
    checks++;
    if (read_data !== 32'h0) begin failures++; $display("FAIL dec_read_miss got=%h exp=0", read_data); end
    mem_read = 1'b0;
    addr     = '0;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL dec_tx_idle got=activity exp=idle"); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_back_to_back();
    test_reset_mid_frame();
    test_addr_decode();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
